// File: rtl/col2img_collect.sv
// Collects one output row of conv results into a line buffer, then streams it
// out as two-word beats. One frame is out_row rows.
module col2img_collect #(
  parameter int row        = 28,
  parameter int kernel     = 5,
  parameter int data_width = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [data_width-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] out1,
  output logic [data_width-1:0] out2,
  output logic                  out_last,
  output logic                  row_done,
  output logic                  frame_done,
  output logic [5:0]            row_cnt
);

  localparam int out_row = row - kernel + 1;
  localparam int beats   = out_row / 2;
  localparam int cw      = (out_row > 1) ? $clog2(out_row) : 1;
  localparam int bw      = (beats > 1) ? $clog2(beats) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] SEND    = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]            state;
  logic [cw-1:0]         col;
  logic [bw-1:0]         beat;
  logic [data_width-1:0] line_buf [out_row];

  logic          accept;
  logic          last_word;
  logic          beat_acc;
  logic          last_beat;
  logic          last_row;
  logic [bw-1:0] beat_nxt;
  logic [cw-1:0] rd_even;
  logic [cw-1:0] rd_odd;

  assign accept    = in_valid & in_ready;
  assign last_word = accept && (col == cw'(out_row - 1));
  assign beat_acc  = out_valid & out_ready;
  assign last_beat = (beat == bw'(beats - 1));
  assign last_row  = (row_cnt == 6'(out_row - 1));
  assign beat_nxt  = beat + 1'b1;
  assign rd_even   = cw'({beat_nxt, 1'b0});
  assign rd_odd    = cw'({beat_nxt, 1'b1});

  // Buffer is left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (accept) line_buf[col] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      col        <= '0;
      beat       <= '0;
      row_cnt    <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out1       <= '0;
      out2       <= '0;
      out_last   <= 1'b0;
      row_done   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      row_done   <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= COLLECT;
            col      <= '0;
            beat     <= '0;
            row_cnt  <= '0;
            in_ready <= 1'b1;
          end
        end
        COLLECT: begin
          if (accept) begin
            if (last_word) begin
              // First beat is loaded here so it is valid right after the last word.
              state     <= SEND;
              col       <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              row_done  <= 1'b1;
              out1      <= line_buf[0];
              out2      <= (out_row == 2) ? in_data : line_buf[1];
              out_last  <= (beats == 1) && last_row;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        SEND: begin
          if (beat_acc) begin
            if (last_beat) begin
              beat      <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              if (last_row) begin
                state      <= DONE;
                frame_done <= 1'b1;
              end else begin
                state    <= COLLECT;
                row_cnt  <= row_cnt + 1'b1;
                in_ready <= 1'b1;
              end
            end else begin
              beat     <= beat_nxt;
              out1     <= line_buf[rd_even];
              out2     <= line_buf[rd_odd];
              out_last <= (beat_nxt == bw'(beats - 1)) && last_row;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_col2img_collect.sv
// Directed frames against col2img_collect: expected beats are (base+2k, base+2k+1).
module tb_col2img_collect;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out1;
  logic [15:0] out2;
  logic        out_last;
  logic        row_done;
  logic        frame_done;
  logic [5:0]  row_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit aborted  = 1'b0;

  always #5 clk = ~clk;

  col2img_collect #(.row(28), .kernel(5), .data_width(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out1(out1), .out2(out2), .out_last(out_last),
    .row_done(row_done), .frame_done(frame_done), .row_cnt(row_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out1"}, out1, 0);
    check({tag, "_out2"}, out2, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_row_done"}, row_done, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_row_cnt"}, row_cnt, 0);
  endtask

  task automatic run_frame(input int base, input bit gaps, input bit stalls,
                           input bit mid_start, input bit abort);
    aborted = 1'b0;
    @(negedge clk);
    check("idle_in_ready", in_ready, 0);
    check("idle_out_valid", out_valid, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("armed_in_ready", in_ready, 1);
    check("armed_row_cnt", row_cnt, 0);
    fork
      begin : producer
        int  n = 0;
        int  cyc = 0;
        int  mid_phase = 0;
        bit  pend = 1'b0;
        bit  v;
        while (n < 576 && !aborted && cyc < 4000) begin
          @(negedge clk);
          cyc++;
          if (pend) begin
            check("row_done_pulse", row_done, 1);
            check("send_entry", out_valid, 1);
            pend = 1'b0;
          end
          if (mid_phase == 1) begin
            start = 1'b0;
            check("mid_start_row_cnt", row_cnt, 3);
            check("mid_start_in_ready", in_ready, 1);
            mid_phase = 2;
          end else if (mid_start && mid_phase == 0 && n == 82) begin
            start = 1'b1;
            mid_phase = 1;
          end
          v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
          in_valid = v;
          in_data  = 16'(base + n);
          if (v && in_ready) begin
            if (n % 24 == 23) pend = 1'b1;
            n++;
          end
        end
        if (!aborted && n < 576) check("producer_timeout", n, 576);
        if (pend && !aborted) begin
          @(negedge clk);
          check("row_done_pulse", row_done, 1);
          check("send_entry", out_valid, 1);
        end
        in_valid = 1'b0;
      end
      begin : consumer
        int k = 0;
        int cyc = 0;
        int rdc = 0;
        bit r;
        while (k < 288 && cyc < 4000 && !aborted) begin
          @(negedge clk);
          cyc++;
          if (row_done) rdc++;
          if (out_valid) begin
            if (abort && k == 63) begin
              rst = 1'b1;
              #1;
              check_zero("abort");
              aborted = 1'b1;
              @(negedge clk);
              rst = 1'b0;
            end else begin
              check("out1", out1, 32'(base + 2 * k));
              check("out2", out2, 32'(base + 2 * k + 1));
              check("out_last", out_last, (k == 287) ? 1 : 0);
              check("beat_row_cnt", row_cnt, 32'(k / 12));
              check("send_in_ready", in_ready, 0);
              r = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
              out_ready = r;
              if (r) k++;
            end
          end else begin
            check("early_frame_done", frame_done, 0);
            out_ready = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
          end
        end
        if (!aborted) begin
          if (k < 288) check("consumer_timeout", k, 288);
          @(negedge clk);
          check("frame_done", frame_done, 1);
          check("done_out_valid", out_valid, 0);
          check("row_done_count", rdc, 24);
        end
      end
    join
    $display("frame base=%0d gaps=%0d stalls=%0d mid_start=%0d abort=%0d complete, failures so far %0d",
             base, gaps, stalls, mid_start, abort, n_fail);
  endtask

  initial begin
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero("post_reset");

    run_frame(0,    1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(0,    1'b0, 1'b1, 1'b0, 1'b0);
    run_frame(0,    1'b1, 1'b0, 1'b0, 1'b0);
    run_frame(2000, 1'b0, 1'b0, 1'b1, 1'b0);
    run_frame(0,    1'b0, 1'b0, 1'b0, 1'b1);
    run_frame(1000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(3000, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
